fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port frame-buffer RAM (80x60, 12-bit RGB444 words) between the camera capture writer and the VGA display reader.
- Display reads take priority, with a fixed 1-cycle latency.
- Capture writes are absorbed by a small write FIFO and drained into idle memory cycles.
- A starvation guard forces a write drain if reads monopolise the port; sits between the capture pipeline, the display block and the RAM.

Parameters:
- c_nb_img_pxls, 13, frame address width (80*60=4800 words).
- c_nb_buf, 12, pixel word width.
- c_nb_wfifo, 2, log2 of write FIFO depth (depth 4).
- c_max_starve, 8, max consecutive cycles a non-empty FIFO may be denied the port.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_req  in  1  display read request, this cycle.
- rd_addr  in  c_nb_img_pxls  display read address.
- rd_gnt  out  1  combinational: read issued to RAM this cycle.
- rd_valid  out  1  registered: rd_data valid (granted read one cycle earlier).
- rd_data  out  c_nb_buf  read data (pass-through of mem_rdata).
- wr_req  in  1  capture write request.
- wr_addr  in  c_nb_img_pxls  capture write address.
- wr_data  in  c_nb_buf  capture pixel.
- wr_ready  out  1  FIFO not full; write accepted when wr_req and wr_ready.
- frame_done  in  1  one-cycle pulse, capture finished a frame.
- rd_bank  out  1  bank currently displayed.
- wr_ovf  out  1  sticky: wr_req seen while wr_ready low.
- mem_addr  out  c_nb_img_pxls+1  RAM address; MSB is the bank bit.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  c_nb_buf  RAM write data.
- mem_rdata  in  c_nb_buf  RAM synchronous read data, valid the cycle after the address.

Behaviour:
- Reset values:
  - Registered: FIFO empty, wr_ready=1, rd_valid=0, wr_ovf=0, starve counter=0, rd_bank=0 (write bank 0), swap_pending=0.
  - Combinational outputs during reset: mem_we=0, rd_gnt=0.
- Port mux (combinational), evaluated each cycle:
  - Priority 1, force write: FIFO non-empty and starve counter == c_max_starve. Pop the head entry, mem_we=1, rd_gnt=0. The read is dropped; the requester retries.
  - Priority 2, read: rd_req=1. mem_addr={read bank, rd_addr}, mem_we=0, rd_gnt=1.
  - Priority 3, drain: FIFO non-empty. mem_we=1, mem_addr={write bank, head addr}, mem_wdata=head data, pop.
  - Otherwise: mem_we=0, mem_addr holds {read bank, rd_addr}.
- Read timing: rd_valid(N+1) = rd_gnt(N). rd_data = mem_rdata, undefined when rd_valid=0.
- Starve counter:
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at c_max_starve.
- FIFO: circular buffer, read/write pointers c_nb_wfifo+1 bits wide; full/empty decoded from the MSB.
  - Push when wr_req and wr_ready.
  - wr_ready = !full, registered. Simultaneous push and pop allowed when neither full nor empty.
  - When full, a pop in the same cycle does not allow a push (no bypass); wr_ready rises the next cycle.
  - Push while empty: the entry is not poppable until the next cycle (no write-through).
- wr_ovf: set on wr_req && !wr_ready. Cleared only by reset.
- Pointer wrap at depth is silent. Reset mid-burst discards FIFO contents; no RAM write is issued after reset asserts.

Optional Feature:
- Macro: FB_DBLBUF_EN.
- With macro defined (ping-pong buffering):
  - Write bank = ~rd_bank.
  - frame_done sets swap_pending.
  - rd_bank toggles on the first cycle where swap_pending=1 and the FIFO is empty with no push that cycle; swap_pending then clears.
  - A frame_done arriving while swap_pending is already set is ignored (single swap).
- Without macro:
  - Bank bit always 0; rd_bank tied 0.
  - frame_done ignored; swap_pending is not implemented.

Test Plan:
- Read only: rd_req=1 at addr 0x005 for 3 cycles, mem_rdata returns 0xABC -> rd_gnt=1 each cycle; rd_valid=1 from cycle 2 on with rd_data=0xABC; mem_we=0.
- Write only: 4 writes to addr 0..3 with data 0x111..0x444, rd_req=0 -> mem_we pulses 4 times in order, addr 0..3; wr_ready stays 1.
- Fill: rd_req=1 held; write 5 pixels back-to-back -> wr_ready=0 after the 4th accept; 5th raises wr_ovf=1 and is not written.
- Starvation: rd_req=1 held, FIFO holds 1 entry -> after 8 denied cycles, one forced write (mem_we=1, rd_gnt=0), then reads resume.
- Double buffer (FB_DBLBUF_EN): frame_done pulse with 2 FIFO entries pending -> both written to bank 1; rd_bank flips 0->1 the cycle after the FIFO empties; subsequent writes go to mem_addr MSB=0.
- Async reset: assert rst=0 mid-drain -> mem_we=0 immediately; wr_ready=1, rd_valid=0, wr_ovf=0 after release.

Source files
------------

// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer arbiter bus: display read port, capture write port and single-port RAM side.
// The arbiter uses the slave modport; the surrounding pipeline/RAM uses master.
interface fb_port_arbiter_if #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
);
    logic                     rd_req;
    logic [c_nb_img_pxls-1:0] rd_addr;
    logic                     rd_gnt;
    logic                     rd_valid;
    logic [c_nb_buf-1:0]      rd_data;
    logic                     wr_req;
    logic [c_nb_img_pxls-1:0] wr_addr;
    logic [c_nb_buf-1:0]      wr_data;
    logic                     wr_ready;
    logic                     frame_done;
    logic                     rd_bank;
    logic                     wr_ovf;
    logic [c_nb_img_pxls:0]   mem_addr;
    logic                     mem_we;
    logic [c_nb_buf-1:0]      mem_wdata;
    logic [c_nb_buf-1:0]      mem_rdata;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, frame_done, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, wr_ready, rd_bank, wr_ovf,
        input  mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, frame_done, mem_rdata,
        output rd_gnt, rd_valid, rd_data, wr_ready, rd_bank, wr_ovf,
        output mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: reads win (1-cycle latency), writes buffered in a 4-deep FIFO and
// drained into idle cycles with a starvation guard; wr_ready backpressures capture. FB_DBLBUF_EN adds ping-pong banks.
module fb_port_arbiter #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_wfifo    = 2,
    parameter int c_max_starve  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fb_port_arbiter_if.slave  io_bus
);
    localparam int c_depth     = 1 << c_nb_wfifo;
    localparam int c_nb_starve = $clog2(c_max_starve + 1);

    typedef struct packed {
        logic [c_nb_img_pxls-1:0] addr;
        logic [c_nb_buf-1:0]      data;
    } wentry_t;

    wentry_t                  r_fifo [c_depth];
    logic [c_nb_wfifo:0]      r_wptr;
    logic [c_nb_wfifo:0]      r_rptr;
    logic                     r_wr_ready;
    logic                     r_rd_valid;
    logic                     r_wr_ovf;
    logic [c_nb_starve-1:0]   r_starve;

    logic [c_nb_wfifo:0]      w_wptr_nxt;
    logic [c_nb_wfifo:0]      w_rptr_nxt;
    logic                     w_empty;
    logic                     w_full_nxt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_force;
    logic                     w_rd_gnt;
    logic                     w_rd_bank;
    logic                     w_wr_bank;
    wentry_t                  w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_head  = r_fifo[r_rptr[c_nb_wfifo-1:0]];
    assign w_push  = io_bus.wr_req && r_wr_ready;
    assign w_force = !w_empty && (r_starve == c_nb_starve'(c_max_starve));

    always_comb begin
        w_pop    = 1'b0;
        w_rd_gnt = 1'b0;
        if (w_force) begin
            w_pop = 1'b1;
        end else if (io_bus.rd_req) begin
            w_rd_gnt = 1'b1;
        end else if (!w_empty) begin
            w_pop = 1'b1;
        end
    end

    // Gate the strobes with reset so nothing reaches the RAM the moment reset asserts.
    assign io_bus.mem_we    = i_rst && w_pop;
    assign io_bus.rd_gnt    = i_rst && w_rd_gnt;
    assign io_bus.mem_addr  = w_pop ? {w_wr_bank, w_head.addr} : {w_rd_bank, io_bus.rd_addr};
    assign io_bus.mem_wdata = w_head.data;
    assign io_bus.rd_data   = io_bus.mem_rdata;
    assign io_bus.rd_valid  = r_rd_valid;
    assign io_bus.wr_ready  = r_wr_ready;
    assign io_bus.wr_ovf    = r_wr_ovf;
    assign io_bus.rd_bank   = w_rd_bank;

    assign w_wptr_nxt = r_wptr + {{c_nb_wfifo{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{c_nb_wfifo{1'b0}}, w_pop};
    assign w_full_nxt = (w_wptr_nxt[c_nb_wfifo] != w_rptr_nxt[c_nb_wfifo]) &&
                        (w_wptr_nxt[c_nb_wfifo-1:0] == w_rptr_nxt[c_nb_wfifo-1:0]);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr[c_nb_wfifo-1:0]] <= '{addr: io_bus.wr_addr, data: io_bus.wr_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
            r_wr_ovf   <= 1'b0;
            r_starve   <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_wr_ready <= !w_full_nxt;
            r_rd_valid <= w_rd_gnt;
            if (io_bus.wr_req && !r_wr_ready) begin
                r_wr_ovf <= 1'b1;
            end
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != c_nb_starve'(c_max_starve)) begin
                r_starve <= r_starve + c_nb_starve'(1);
            end
        end
    end

`ifdef FB_DBLBUF_EN
    logic r_rd_bank;
    logic r_swap_pending;

    // Swap only once every buffered pixel of the finished frame has landed in the back bank.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_bank      <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (r_swap_pending && w_empty && !w_push) begin
            r_rd_bank      <= ~r_rd_bank;
            r_swap_pending <= 1'b0;
        end else if (io_bus.frame_done) begin
            r_swap_pending <= 1'b1;
        end
    end

    assign w_rd_bank = r_rd_bank;
    assign w_wr_bank = ~r_rd_bank;
`else
    logic w_unused_frame_done;

    assign w_unused_frame_done = io_bus.frame_done;
    assign w_rd_bank           = 1'b0;
    assign w_wr_bank           = 1'b0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios with literal expectations plus a random phase,
// all cycles also compared against a queue-based model of the arbitration rules.
module tb_fb_port_arbiter;
    localparam int AW    = 13;
    localparam int DW    = 12;
    localparam int MAXS  = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.c_nb_img_pxls(AW), .c_nb_buf(DW)) bus ();

    fb_port_arbiter #(
        .c_nb_img_pxls(AW), .c_nb_buf(DW), .c_nb_wfifo(2), .c_max_starve(MAXS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    logic [DW-1:0] ram [1 << (AW + 1)];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } went_t;

    went_t         q[$];
    logic [DW-1:0] shadow [int];
    int            starve;
    int            m_n;
    bit            m_ovf, m_rv, m_rv_chk, m_rbank, m_pend, m_wbank;
    bit            e_ready, e_force, e_gnt, e_we, e_push;
    logic [AW:0]   e_addr;
    logic [DW-1:0] m_rdat;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            starve   = 0;
            m_ovf    = 0;
            m_rv     = 0;
            m_rv_chk = 0;
            m_rbank  = 0;
            m_pend   = 0;
        end else begin
            m_n     = q.size();
`ifdef FB_DBLBUF_EN
            m_wbank = !m_rbank;
`else
            m_wbank = 1'b0;
`endif
            e_ready = (m_n < DEPTH);
            e_force = (m_n > 0) && (starve == MAXS);
            e_gnt   = !e_force && bus.rd_req;
            e_we    = (m_n > 0) && (e_force || !bus.rd_req);
            e_addr  = e_we ? {m_wbank, q[0].a} : {m_rbank, bus.rd_addr};

            chk("m_rd_gnt",   32'(bus.rd_gnt),   32'(e_gnt));
            chk("m_mem_we",   32'(bus.mem_we),   32'(e_we));
            chk("m_mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (e_we) chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(q[0].d));
            chk("m_wr_ready", 32'(bus.wr_ready), 32'(e_ready));
            chk("m_wr_ovf",   32'(bus.wr_ovf),   32'(m_ovf));
            chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_rv));
            if (m_rv && m_rv_chk) chk("m_rd_data", 32'(bus.rd_data), 32'(m_rdat));
            chk("m_rd_bank",  32'(bus.rd_bank),  32'(m_rbank));

            e_push = bus.wr_req && e_ready;
            if (bus.wr_req && !e_ready) m_ovf = 1;
            if (e_we) begin
                shadow[int'(e_addr)] = q[0].d;
                void'(q.pop_front());
            end
            starve   = (m_n == 0 || e_we) ? 0 : ((starve < MAXS) ? starve + 1 : MAXS);
            m_rv     = e_gnt;
            m_rv_chk = e_gnt && shadow.exists(int'({m_rbank, bus.rd_addr}));
            if (m_rv_chk) m_rdat = shadow[int'({m_rbank, bus.rd_addr})];
`ifdef FB_DBLBUF_EN
            if (m_pend && m_n == 0 && !e_push) begin
                m_rbank = !m_rbank;
                m_pend  = 0;
            end else if (bus.frame_done) begin
                m_pend = 1;
            end
`endif
            if (e_push) q.push_back('{a: bus.wr_addr, d: bus.wr_data});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int we_cnt;

    initial begin
        idle();
        bus.rd_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_gnt",   32'(bus.rd_gnt),   32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_wr_ovf",   32'(bus.wr_ovf),   32'd0);
        chk("rst_rd_bank",  32'(bus.rd_bank),  32'd0);
        step();
        rst = 1'b1;
        idle();

        // Write only: four pixels drained in order on the following cycles.
        for (int k = 0; k < 6; k++) begin
            bus.wr_req  = (k < 4);
            bus.wr_addr = AW'(k);
            bus.wr_data = DW'((k + 1) * 'h111);
            @(negedge clk);
            chk("wo_mem_we", 32'(bus.mem_we), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk("wo_mem_addr",  32'(bus.mem_addr[AW-1:0]), 32'(k - 1));
                chk("wo_mem_wdata", 32'(bus.mem_wdata),        32'(k * 'h111));
            end
            chk("wo_wr_ready", 32'(bus.wr_ready), 32'd1);
            step();
        end

        // Read only: place 0xABC at address 5, then read it three cycles in a row.
        idle();
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'(5);
        bus.wr_data = DW'('hABC);
        step();
        idle();
        step();
        for (int j = 0; j < 3; j++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = AW'(5);
            @(negedge clk);
            chk("ro_rd_gnt",   32'(bus.rd_gnt),   32'd1);
            chk("ro_mem_we",   32'(bus.mem_we),   32'd0);
            chk("ro_rd_valid", 32'(bus.rd_valid), 32'(j >= 1));
`ifndef FB_DBLBUF_EN
            if (j >= 1) chk("ro_rd_data", 32'(bus.rd_data), 32'h0ABC);
`endif
            step();
        end

        // Starvation: one queued write behind a continuous read stream.
        idle();
        for (int j = 0; j < 11; j++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = AW'(j);
            bus.wr_req  = (j == 0);
            bus.wr_addr = AW'(7);
            bus.wr_data = DW'('h777);
            @(negedge clk);
            chk("st_mem_we", 32'(bus.mem_we), 32'(j == 9));
            chk("st_rd_gnt", 32'(bus.rd_gnt), 32'(j != 9));
            if (j == 9) chk("st_mem_addr", 32'(bus.mem_addr[AW-1:0]), 32'd7);
            if (j == 10) chk("st_rd_valid", 32'(bus.rd_valid), 32'd0);
            step();
        end

        // Fill: five back-to-back writes while reads hold the port.
        idle();
        we_cnt = 0;
        for (int j = 0; j < 15; j++) begin
            bus.rd_req  = (j < 10);
            bus.rd_addr = AW'(j);
            bus.wr_req  = (j < 5);
            bus.wr_addr = AW'(8 + j);
            bus.wr_data = DW'('h500 + j);
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            if (j < 4) chk("fl_wr_ready_hi", 32'(bus.wr_ready), 32'd1);
            if (j == 4) chk("fl_wr_ready_lo", 32'(bus.wr_ready), 32'd0);
            if (j == 5) chk("fl_wr_ovf", 32'(bus.wr_ovf), 32'd1);
            if (j == 9) begin
                chk("fl_force_we",   32'(bus.mem_we),             32'd1);
                chk("fl_force_addr", 32'(bus.mem_addr[AW-1:0]),   32'd8);
            end
            if (j == 10) chk("fl_wr_ready_back", 32'(bus.wr_ready), 32'd1);
            step();
        end
        chk("fl_write_count", 32'(we_cnt), 32'd4);

`ifdef FB_DBLBUF_EN
        // Ping-pong: frame_done with two entries pending swaps after the drain completes.
        idle();
        for (int j = 0; j < 6; j++) begin
            bus.wr_req     = (j == 0 || j == 1 || j == 4);
            bus.wr_addr    = AW'('h20 + j);
            bus.wr_data    = DW'('h600 + j);
            bus.frame_done = (j == 1);
            @(negedge clk);
            if (j == 1 || j == 2) begin
                chk("db_we",   32'(bus.mem_we),      32'd1);
                chk("db_bank", 32'(bus.mem_addr[AW]), 32'd1);
            end
            if (j == 3) chk("db_rd_bank_old", 32'(bus.rd_bank), 32'd0);
            if (j == 4) chk("db_rd_bank_new", 32'(bus.rd_bank), 32'd1);
            if (j == 5) chk("db_bank_after",  32'(bus.mem_addr[AW]), 32'd0);
            step();
        end
`endif

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            bus.rd_req     = ($urandom_range(99) < 60);
            bus.rd_addr    = AW'($urandom_range(31));
            bus.wr_req     = ($urandom_range(99) < 50);
            bus.wr_addr    = AW'($urandom_range(31));
            bus.wr_data    = DW'($urandom);
            bus.frame_done = ($urandom_range(99) < 4);
            step();
        end

        // Async reset asserted in the middle of a drain.
        idle();
        step();
        step();
        for (int j = 0; j < 3; j++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = AW'('h30 + j);
            bus.wr_data = DW'('h700 + j);
            step();
        end
        idle();
        chk("ar_we_before", 32'(bus.mem_we), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_we_during",  32'(bus.mem_we), 32'd0);
        chk("ar_gnt_during", 32'(bus.rd_gnt), 32'd0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("ar_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("ar_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("ar_wr_ovf",   32'(bus.wr_ovf),   32'd0);
        chk("ar_mem_we",   32'(bus.mem_we),   32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
